// File: rtl/mm_tile_control_if.sv
// Host-control and operand-read signal bundle for the matrix-multiply tile sequencer.
// Field widths are derived from the same geometry parameters as the sequencer itself.
interface mm_tile_control_if #(
  parameter int N1    = 4,
  parameter int N2    = 4,
  parameter int ROWS  = 8,
  parameter int INNER = 8,
  parameter int COLS  = 8
);
  localparam int KW  = (INNER > 1) ? $clog2(INNER) : 1;
  localparam int SAW = (ROWS / N1 > 1) ? $clog2(ROWS / N1) : 1;
  localparam int SBW = (COLS / N2 > 1) ? $clog2(COLS / N2) : 1;
  localparam int AAW = (ROWS * INNER / N1 > 1) ? $clog2(ROWS * INNER / N1) : 1;
  localparam int BAW = (COLS * INNER / N2 > 1) ? $clog2(COLS * INNER / N2) : 1;

  logic           start;
  logic           stall;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [KW-1:0]  k_cntr;
  logic [SAW-1:0] slice_cntr_A;
  logic [SBW-1:0] slice_cntr_B;
  logic [AAW-1:0] rd_addr_A;
  logic [BAW-1:0] rd_addr_B;
  logic           first_k;
  logic           last_k;
  logic           tile_done;

  modport master (
    output start, stall,
    input  busy, done, rd_en, k_cntr, slice_cntr_A, slice_cntr_B,
           rd_addr_A, rd_addr_B, first_k, last_k, tile_done
  );

  modport slave (
    input  start, stall,
    output busy, done, rd_en, k_cntr, slice_cntr_A, slice_cntr_B,
           rd_addr_A, rd_addr_B, first_k, last_k, tile_done
  );
endinterface

// File: rtl/mm_tile_control.sv
// Run-time sequencer for the N1 x N2 systolic array: walks every (A-slice, B-slice)
// tile pair, streams INNER operand addresses per tile, then drains the array.
module mm_tile_control #(
  parameter int N1        = 4,
  parameter int N2        = 4,
  parameter int ROWS      = 8,
  parameter int INNER     = 8,
  parameter int COLS      = 8,
  parameter int DRAIN_CYC = N1 + N2 - 2
) (
  input  logic             clk,
  input  logic             rst,
  mm_tile_control_if.slave bus
);
  localparam int NSA = ROWS / N1;
  localparam int NSB = COLS / N2;
  localparam int KW  = (INNER > 1) ? $clog2(INNER) : 1;
  localparam int SAW = (NSA > 1) ? $clog2(NSA) : 1;
  localparam int SBW = (NSB > 1) ? $clog2(NSB) : 1;
  localparam int AAW = (ROWS * INNER / N1 > 1) ? $clog2(ROWS * INNER / N1) : 1;
  localparam int BAW = (COLS * INNER / N2 > 1) ? $clog2(COLS * INNER / N2) : 1;
  localparam int DW  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  if (N1 < 1 || N2 < 1 || INNER < 1 || DRAIN_CYC < 0 ||
      ROWS % N1 != 0 || COLS % N2 != 0 || ROWS < N1 || COLS < N2) begin : g_bad_params
    $error("mm_tile_control: illegal geometry parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         r_state;
  logic [KW-1:0]  r_k;
  logic [DW-1:0]  r_d;
  logic [SAW-1:0] r_sa;
  logic [SBW-1:0] r_sb;

  state_t         w_end_state;
  logic [SAW-1:0] w_end_sa;
  logic [SBW-1:0] w_end_sb;
  logic           w_last_k_idx;
  logic           w_last_d;
  logic           w_rd_en;

  assign w_last_k_idx = (r_k == KW'(INNER - 1));
  assign w_last_d     = (r_d == DW'(DRAIN_CYC - 1));

  // Tile-end successor: B slice is the inner loop so each A slice is reused across all of B.
  always_comb begin
    w_end_state = S_RUN;
    w_end_sa    = r_sa;
    w_end_sb    = r_sb;
    if (r_sb != SBW'(NSB - 1)) begin
      w_end_sb = r_sb + SBW'(1);
    end else if (r_sa != SAW'(NSA - 1)) begin
      w_end_sb = '0;
      w_end_sa = r_sa + SAW'(1);
    end else begin
      w_end_state = S_DONE;
    end
  end

  // Stall freezes everything except IDLE, where a start must still be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_d     <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.start) begin
        r_state <= S_RUN;
        r_k     <= '0;
        r_d     <= '0;
        r_sa    <= '0;
        r_sb    <= '0;
      end
    end else if (!bus.stall) begin
      case (r_state)
        S_RUN: begin
          if (w_last_k_idx) begin
            r_k <= '0;
            if (DRAIN_CYC > 0) begin
              r_state <= S_DRAIN;
              r_d     <= '0;
            end else begin
              r_state <= w_end_state;
              r_sa    <= w_end_sa;
              r_sb    <= w_end_sb;
            end
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DRAIN: begin
          if (w_last_d) begin
            r_d     <= '0;
            r_state <= w_end_state;
            r_sa    <= w_end_sa;
            r_sb    <= w_end_sb;
          end else begin
            r_d <= r_d + DW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_rd_en          = (r_state == S_RUN) && !bus.stall;
  assign bus.rd_en        = w_rd_en;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_DONE) && !bus.stall;
  assign bus.first_k      = w_rd_en && (r_k == '0);
  assign bus.last_k       = w_rd_en && w_last_k_idx;
  assign bus.tile_done    = (DRAIN_CYC > 0) ? ((r_state == S_DRAIN) && !bus.stall && w_last_d)
                                            : (w_rd_en && w_last_k_idx);
  assign bus.k_cntr       = r_k;
  assign bus.slice_cntr_A = r_sa;
  assign bus.slice_cntr_B = r_sb;
  assign bus.rd_addr_A    = AAW'(r_sa) * AAW'(INNER) + AAW'(r_k);
  assign bus.rd_addr_B    = BAW'(r_sb) * BAW'(INNER) + BAW'(r_k);
endmodule

// File: tb/tb_mm_tile_control.sv
// Directed bench for mm_tile_control: default 8x8x8 instance plus a non-square, no-drain instance.
module tb_mm_tile_control;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mm_tile_control_if b0 ();
  mm_tile_control_if #(.N1(2), .N2(4), .ROWS(4), .INNER(3), .COLS(8)) b1 ();

  mm_tile_control u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mm_tile_control #(.N1(2), .N2(4), .ROWS(4), .INNER(3), .COLS(8), .DRAIN_CYC(0))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct {int a; int b; int f; int l;} rd_t;
  rd_t q_rd[$];
  int  q_td[$];
  int  cyc, done_at, n_cmp, n_err;
  bit  job_on, sel;

  logic s_rd_en, s_first, s_last, s_td, s_done, s_busy;
  int   s_a, s_b, s_k, s_sa, s_sb;

  always_comb begin
    s_rd_en = sel ? b1.rd_en     : b0.rd_en;
    s_first = sel ? b1.first_k   : b0.first_k;
    s_last  = sel ? b1.last_k    : b0.last_k;
    s_td    = sel ? b1.tile_done : b0.tile_done;
    s_done  = sel ? b1.done      : b0.done;
    s_busy  = sel ? b1.busy      : b0.busy;
    s_a     = sel ? int'(b1.rd_addr_A)    : int'(b0.rd_addr_A);
    s_b     = sel ? int'(b1.rd_addr_B)    : int'(b0.rd_addr_B);
    s_k     = sel ? int'(b1.k_cntr)       : int'(b0.k_cntr);
    s_sa    = sel ? int'(b1.slice_cntr_A) : int'(b0.slice_cntr_A);
    s_sb    = sel ? int'(b1.slice_cntr_B) : int'(b0.slice_cntr_B);
  end

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_zero(string pfx);
    chk({pfx, "_busy"},  int'(s_busy), 0);
    chk({pfx, "_rd_en"}, int'(s_rd_en), 0);
    chk({pfx, "_done"},  int'(s_done), 0);
    chk({pfx, "_tdone"}, int'(s_td), 0);
    chk({pfx, "_first"}, int'(s_first), 0);
    chk({pfx, "_last"},  int'(s_last), 0);
    chk({pfx, "_k"},     s_k, 0);
    chk({pfx, "_sa"},    s_sa, 0);
    chk({pfx, "_sb"},    s_sb, 0);
    chk({pfx, "_addrA"}, s_a, 0);
    chk({pfx, "_addrB"}, s_b, 0);
  endtask

  task automatic check_cycle();
    rd_t e;
    int  exp_td;
    if (s_rd_en) begin
      chk("rd_avail", int'(q_rd.size() > 0), 1);
      if (q_rd.size() > 0) begin
        e = q_rd.pop_front();
        chk("addrA",   s_a, e.a);
        chk("addrB",   s_b, e.b);
        chk("first_k", int'(s_first), e.f);
        chk("last_k",  int'(s_last),  e.l);
      end
    end else begin
      chk("first_k_idle", int'(s_first), 0);
      chk("last_k_idle",  int'(s_last),  0);
    end
    exp_td = int'(q_td.size() > 0 && q_td[0] == cyc);
    chk("tile_done", int'(s_td), exp_td);
    if (exp_td == 1) void'(q_td.pop_front());
    chk("done", int'(s_done), int'(job_on && cyc == done_at));
    chk("busy", int'(s_busy), int'(job_on && cyc >= 1 && cyc <= done_at));
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(int c);
    while (cyc < c) tick();
  endtask

  task automatic set_start(logic v);
    if (sel) b1.start = v; else b0.start = v;
  endtask

  task automatic set_stall(logic v);
    if (sel) b1.stall = v; else b0.stall = v;
  endtask

  // Expected reads and event cycles, relative to the cycle in which start is driven.
  task automatic push_job(int shift);
    int na, nb, inner, drain, t;
    rd_t e;
    na    = sel ? 2 : 2;
    nb    = sel ? 2 : 2;
    inner = sel ? 3 : 8;
    drain = sel ? 0 : 6;
    for (int sa = 0; sa < na; sa++)
      for (int sb = 0; sb < nb; sb++)
        for (int k = 0; k < inner; k++) begin
          e.a = sa * inner + k;
          e.b = sb * inner + k;
          e.f = int'(k == 0);
          e.l = int'(k == inner - 1);
          q_rd.push_back(e);
        end
    for (t = 0; t < na * nb; t++) q_td.push_back((t + 1) * (inner + drain) + shift);
    done_at = na * nb * (inner + drain) + 1 + shift;
    job_on  = 1'b1;
    cyc     = 0;
  endtask

  task automatic start_job(int shift);
    set_start(1'b1);
    push_job(shift);
    tick();
    set_start(1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; done_at = 0; job_on = 1'b0; sel = 1'b0;
    rst = 1'b0;
    b0.start = 1'b0; b0.stall = 1'b0;
    b1.start = 1'b0; b1.stall = 1'b0;
    #2;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    tick(); tick();

    // Default job with stray start pulses during RUN.
    start_job(0);
    run_to(3);  set_start(1'b1); tick(); set_start(1'b0);
    run_to(29);
    chk("t10_addrA", s_a, 8);
    chk("t10_first", int'(s_first), 1);
    run_to(30); set_start(1'b1); tick(); set_start(1'b0);
    run_to(done_at + 1);

    // Back-to-back start in the cycle after done, with a 3-cycle stall at k=4 of tile 0.
    start_job(3);
    run_to(5);
    set_stall(1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rd_en", int'(s_rd_en), 0);
      chk("stall_k",     s_k, 4);
      chk("stall_addrA", s_a, 4);
      tick();
    end
    set_stall(1'b0);
    run_to(done_at + 1);

    // Reset during tile 2 drain aborts the job; a new start runs a fresh job.
    start_job(0);
    run_to(38);
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    q_rd.delete(); q_td.delete(); job_on = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    start_job(0);
    run_to(done_at + 1);

    // Non-square geometry without drain.
    sel = 1'b1;
    tick();
    start_job(0);
    run_to(done_at + 1);

    chk("rd_left", q_rd.size(), 0);
    chk("td_left", q_td.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mm_tile_control.md
Name: mm_tile_control

Overview:
- Run-time sequencer for the N1 x N2 systolic matrix-multiply array. Computes C[ROWS x COLS] = A[ROWS x INNER] * B[INNER x COLS].
- Walks every (A-slice, B-slice) tile pair and streams INNER read addresses per tile into the sliced A/B BRAMs.
- Adds a start/busy/done handshake, stall support, accumulator first/last flags and a per-tile drain phase.
- Sits between the host control registers and the A/B operand memories.

Parameters:
- N1, 4, array rows; A is split into ROWS/N1 slices.
- N2, 4, array columns; B is split into COLS/N2 slices.
- ROWS, 8, rows of A; must be a multiple of N1.
- INNER, 8, shared dimension; number of k steps per tile.
- COLS, 8, columns of B; must be a multiple of N2.
- DRAIN_CYC, N1+N2-2, idle cycles after each tile's last k to flush the array; 0 means no drain.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- stall  in  1  active-high; freezes all counters, state and strobes.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when the whole job is complete.
- rd_en  out  1  operand read valid (RUN state and not stalled).
- k_cntr  out  KW=max(1,clog2(INNER))  current k index.
- slice_cntr_A  out  SAW=max(1,clog2(ROWS/N1))  current A slice.
- slice_cntr_B  out  SBW=max(1,clog2(COLS/N2))  current B slice.
- rd_addr_A  out  max(1,clog2(ROWS*INNER/N1))  equals slice_cntr_A*INNER + k_cntr.
- rd_addr_B  out  max(1,clog2(COLS*INNER/N2))  equals slice_cntr_B*INNER + k_cntr.
- first_k  out  1  rd_en and k_cntr==0; clears the accumulators.
- last_k  out  1  rd_en and k_cntr==INNER-1.
- tile_done  out  1  one-cycle pulse when a tile's results are valid in the array.

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. Every output and counter is 0. Deassertion is synchronous to clk.
- A reset mid-job aborts the job immediately. No done or tile_done is generated.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 at an edge moves to RUN at that edge, with k=0, sa=0, sb=0.
  - rd_en is 1 in the first following cycle, so latency from start to first address is 1 cycle.
- RUN:
  - Each non-stalled cycle, k increments.
  - At k==INNER-1: k wraps to 0, then go to DRAIN (DRAIN_CYC>0) or to tile end (DRAIN_CYC==0).
- DRAIN:
  - Drain counter counts 0..DRAIN_CYC-1.
  - tile_done asserts combinationally in the last drain cycle. If DRAIN_CYC==0, it asserts on the last_k cycle instead.
- Tile end and loop order:
  - sb is the inner loop, sa the outer loop, so each A slice is reused across all B slices.
  - If sb<COLS/N2-1: sb++ and return to RUN.
  - Else if sa<ROWS/N1-1: sb=0, sa++ and return to RUN.
  - Else go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- stall=1:
  - State, k, the drain counter and the slice counters hold.
  - rd_en, first_k, last_k, tile_done and done are forced to 0. done is held pending and issues once stall drops.
  - Addresses stay stable.
  - In IDLE, stall has no effect; start is still accepted.
- start while busy is ignored. A back-to-back start in the cycle after done is accepted.
- Address products use truncating width arithmetic. Parameter legality (multiples, INNER>=1) is checked by an elaboration-time assertion.
- Addresses are driven from the registered counters (combinational from registers). No address changes while rd_en=0 except on state transitions.

Test Plan:
- Defaults, single start:
  - 4 tiles in order (0,0),(0,1),(1,0),(1,1).
  - Each tile gives 8 rd_en cycles, then 6 drain cycles, then a tile_done pulse.
  - First rd_en at cycle 1; tile_done at cycles 14, 28, 42, 56; done at cycle 57; busy low at 58.
- Address check, tile (1,0): rd_addr_A = 8..15 and rd_addr_B = 0..7. first_k on address 8, last_k on address 15.
- Stall:
  - Assert stall for 3 cycles at k=4 of tile 0.
  - k and addresses hold at 4 with rd_en=0. Job completion shifts by exactly 3 cycles (done at 60).
- Reset mid-job: drop rst during tile 2's DRAIN.
  - All outputs 0 immediately, no done.
  - A new start gives a fresh job from tile (0,0).
- Start handling:
  - start pulses during RUN are ignored.
  - start in the cycle after done begins a new job; first rd_en is 1 cycle later.
- Non-square case: N1=2, N2=4, ROWS=4, INNER=3, COLS=8, DRAIN_CYC=0.
  - 2x2 tiles of 3 cycles each; tile_done coincides with last_k.
  - rd_addr_A walks 0..2,0..2,3..5,3..5; done at cycle 13.
